// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate cache with its backing memory, every access in one edge.
module dcache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] read_addr,
    input  logic [16:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data
);
    // Memory holds value XOR address, so the all-zero power-up image reads back as mem[A] = A.
    logic [31:0]       mem_q [131072];
    logic [15:0][31:0] line_q [1024];
    logic [2:0]        tag_q [1024];
    logic [1023:0]     valid_q, valid_d, dirty_q, dirty_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              wr, rd, hit, wb;
    logic [2:0]        tag;
    logic [9:0]        idx;
    logic [3:0]        off;
    logic [15:0][31:0] fill, base, line_d;

    assign wr = write_enable;
    assign rd = read_enable & ~write_enable;
    assign {tag, idx, off} = wr ? write_addr : read_addr;
    assign hit = valid_q[idx] && tag_q[idx] == tag;
    assign wb = (wr | rd) && !hit && valid_q[idx] && dirty_q[idx];
    assign read_data = read_data_q;

    always_comb begin
        for (int w = 0; w < 16; w++) fill[w] = mem_q[{tag, idx, 4'(w)}] ^ {15'b0, tag, idx, 4'(w)};
        base = hit ? line_q[idx] : fill;
        line_d = base;
        if (wr) line_d[off] = write_data;
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        read_data_d = rd ? base[off] : read_data_q;
        if (wr | rd) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = wr | (hit & dirty_q[idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            read_data_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            read_data_q <= read_data_d;
        end
    end

    // Unreset storage; gated by rst_n so no access lands while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && (wr | rd)) begin
            tag_q[idx] <= tag;
            line_q[idx] <= line_d;
            if (wb)
                for (int w = 0; w < 16; w++)
                    mem_q[{tag_q[idx], idx, 4'(w)}] <= line_q[idx][w] ^ {15'b0, tag_q[idx], idx, 4'(w)};
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized and directed checks of dcache against an architectural memory model.
module tb_dcache;
    logic        clk = 0, rst_n = 1;
    logic [16:0] read_addr = 0, write_addr = 0;
    logic [31:0] write_data = 0;
    logic        read_enable = 0, write_enable = 0;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    dcache dut (
        .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .write_addr(write_addr),
        .write_data(write_data), .read_enable(read_enable), .write_enable(write_enable),
        .read_data(read_data)
    );

    int n_cmp = 0, n_fail = 0;
    // arch: value a read must return; pmem: backing memory; dirty lines live only in arch.
    int unsigned pmem [131072];
    int unsigned arch [131072];
    int          res_tag [1024];
    bit          res_dirty [1024];
    logic [31:0] exp_rd;

    typedef struct {bit re; bit we; logic [16:0] a; logic [31:0] d; logic [31:0] exp;} step_t;

    function automatic int la(int tag, int idx, int w);
        return (tag << 14) | (idx << 4) | w;
    endfunction

    function automatic void m_access(bit rd, bit wr, int a, logic [31:0] d);
        int idx = (a >> 4) & 1023;
        int tag = a >> 14;
        if (!rd && !wr) return;
        if (res_tag[idx] != tag) begin
            if (res_tag[idx] >= 0 && res_dirty[idx])
                for (int w = 0; w < 16; w++) pmem[la(res_tag[idx], idx, w)] = arch[la(res_tag[idx], idx, w)];
            res_tag[idx] = tag;
            res_dirty[idx] = 0;
        end
        if (wr) begin
            arch[a] = d;
            res_dirty[idx] = 1;
        end else exp_rd = arch[a];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 1024; i++) begin
            if (res_tag[i] >= 0 && res_dirty[i])
                for (int w = 0; w < 16; w++) arch[la(res_tag[i], i, w)] = pmem[la(res_tag[i], i, w)];
            res_tag[i] = -1;
            res_dirty[i] = 0;
        end
        exp_rd = 0;
    endfunction

    task automatic op(input bit re, input bit we, input logic [16:0] a, input logic [31:0] d);
        @(negedge clk);
        read_enable = re;
        write_enable = we;
        read_addr = a;
        write_addr = a;
        write_data = d;
        @(posedge clk);
        #1;
        m_access(re, we, int'(a), d);
        read_enable = 0;
        write_enable = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_now read_data=%h exp=%h", read_data, 32'h0); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_held read_data=%h exp=%h", read_data, 32'h0); end
        @(negedge clk) rst_n = 1;
        m_reset();
    endtask

    task automatic test_directed();
        step_t s [10] = '{
            '{1, 0, 17'h1380B, 32'h0,        32'h0001380B},
            '{0, 1, 17'h1380B, 32'h11111FFF, 32'h0001380B},
            '{1, 0, 17'h1380B, 32'h0,        32'h11111FFF},
            '{1, 0, 17'h1F80B, 32'h0,        32'h0001F80B},
            '{1, 0, 17'h1380B, 32'h0,        32'h11111FFF},
            '{0, 1, 17'h1780B, 32'hAAAA1111, 32'h11111FFF},
            '{1, 0, 17'h1780B, 32'h0,        32'hAAAA1111},
            '{1, 0, 17'h1780A, 32'h0,        32'h0001780A},
            '{1, 1, 17'h00005, 32'hDEADBEEF, 32'h0001780A},
            '{1, 0, 17'h00005, 32'h0,        32'hDEADBEEF}
        };
        for (int i = 0; i < 10; i++) begin
            op(s[i].re, s[i].we, s[i].a, s[i].d);
            n_cmp++;
            if (read_data !== s[i].exp) begin
                n_fail++;
                $display("FAIL directed[%0d] addr=%h read_data=%h exp=%h", i, s[i].a, read_data, s[i].exp);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t s [4] = '{
            '{1, 0, 17'h00123, 0, 32'h00000123},
            '{1, 0, 17'h1380B, 0, 32'h11111FFF},
            '{1, 0, 17'h00005, 0, 32'h00000005},
            '{1, 0, 17'h1780B, 0, 32'h0001780B}
        };
        op(0, 1, 17'h00123, 32'h12345678);
        op(1, 0, 17'h00123, 32'h0);
        n_cmp++;
        if (read_data !== 32'h12345678) begin n_fail++; $display("FAIL pre_reset_read read_data=%h exp=%h", read_data, 32'h12345678); end
        @(posedge clk);
        #3;
        write_enable = 1;
        write_addr = 17'h00123;
        write_data = 32'h55555555;
        rst_n = 0;
        #1;
        n_cmp++;
        if (read_data !== 32'h0) begin n_fail++; $display("FAIL async_clear read_data=%h exp=%h", read_data, 32'h0); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        write_enable = 0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            op(s[i].re, s[i].we, s[i].a, s[i].d);
            n_cmp++;
            if (read_data !== s[i].exp) begin
                n_fail++;
                $display("FAIL after_reset[%0d] addr=%h read_data=%h exp=%h", i, s[i].a, read_data, s[i].exp);
            end
        end
    endtask

    task automatic test_idle();
        logic [16:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 17'($urandom);
            op(0, 0, a, $urandom);
            @(posedge clk);
            #2;
            write_enable = 1;
            write_addr = a;
            write_data = 32'hBADBAD00;
            #2;
            write_enable = 0;
            n_cmp++;
            if (read_data !== exp_rd) begin n_fail++; $display("FAIL idle[%0d] read_data=%h exp=%h", i, read_data, exp_rd); end
            op(1, 0, a, 0);
            n_cmp++;
            if (read_data !== exp_rd) begin n_fail++; $display("FAIL idle_read[%0d] addr=%h read_data=%h exp=%h", i, a, read_data, exp_rd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] a = 17'h0A3F0;
        logic [31:0] d = $urandom;
        @(negedge clk);
        write_enable = 1;
        write_addr = a;
        write_data = d;
        repeat (3) @(posedge clk);
        #1;
        write_enable = 0;
        for (int i = 0; i < 3; i++) m_access(0, 1, int'(a), d);
        op(1, 0, a, 0);
        n_cmp++;
        if (read_data !== d) begin n_fail++; $display("FAIL repeat_write read_data=%h exp=%h", read_data, d); end
        for (int i = 0; i < 4; i++) begin
            a = 17'(la(i, 1023, 15 - i));
            op(1, 0, a, 0);
            n_cmp++;
            if (read_data !== exp_rd) begin n_fail++; $display("FAIL b2b_read[%0d] addr=%h read_data=%h exp=%h", i, a, read_data, exp_rd); end
        end
    endtask

    task automatic test_index_wrap();
        int idxs [4] = '{0, 1023, 0, 1023};
        int offs [4] = '{0, 15, 15, 0};
        logic [16:0] a;
        for (int i = 0; i < 4; i++) op(0, 1, 17'(la(5, idxs[i], offs[i])), 32'hC0DE0000 + i);
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 16; w += 5) begin
                a = 17'(la(5, idxs[i], (offs[i] + w) % 16));
                op(1, 0, a, 0);
                n_cmp++;
                if (read_data !== exp_rd) begin n_fail++; $display("FAIL wrap addr=%h read_data=%h exp=%h", a, read_data, exp_rd); end
            end
    endtask

    task automatic test_random();
        int idxs [4] = '{0, 1, 512, 1023};
        logic [16:0] a;
        bit re, we;
        for (int i = 0; i < 400; i++) begin
            a = 17'(la(int'($urandom_range(7)), idxs[$urandom_range(3)], int'($urandom_range(15))));
            we = ($urandom_range(2) == 0);
            re = ($urandom_range(3) != 0);
            op(re, we, a, $urandom);
            n_cmp++;
            if (read_data !== exp_rd) begin
                n_fail++;
                $display("FAIL random[%0d] re=%0b we=%0b addr=%h read_data=%h exp=%h", i, re, we, a, read_data, exp_rd);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) begin
            pmem[a] = a;
            arch[a] = a;
        end
        for (int i = 0; i < 1024; i++) res_tag[i] = -1;
        test_reset();
        test_directed();
        test_async_reset();
        test_idle();
        test_back_to_back();
        test_index_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache for a 17-bit word-addressed, 32-bit data space, with its backing main memory modelled inside the block. It sits between a simple load/store requester and memory. Every read or write completes in a single clock edge, including miss fill and dirty-line write-back, so the block needs no stall or ready handshake.

## Interface
Parameters: none. Geometry is fixed: 3-bit tag, 10-bit index (1024 lines), 4-bit word offset (16 words of 32 bits per line).

- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- read_addr  input  17  read word address: [16:14] tag, [13:4] index, [3:0] word offset.
- write_addr  input  17  write word address, same field split.
- write_data  input  32  write data.
- read_enable  input  1  request a read at this edge.
- write_enable  input  1  request a write at this edge.
- read_data  output  32  registered read result; holds its value between reads.

## Operation
- Storage per line: valid bit, dirty bit, 3-bit tag, 16×32-bit data words.
- Main memory: 131072 × 32-bit words. Initialized once at time zero to mem[A] = zero-extended A (for example, word 0x1380B holds 0x0001380B). Reset does not affect main memory.
- Hit means the line is valid and its stored tag equals the address tag.
- Read hit: read_data is loaded with the addressed word.
- Read miss:
  - If the resident line is valid and dirty, write its 16 words back to main memory at {old tag, index, 0..15}.
  - Fill all 16 words from {new tag, index, 0..15}.
  - Set valid=1, dirty=0, tag=new tag.
  - Load read_data with the addressed word from the newly fetched data.
- Write hit: the addressed word is replaced by write_data and dirty is set to 1. Main memory is not updated.
- Write miss:
  - Write back the resident line if it is dirty, as for a read miss.
  - Fill the line from memory.
  - Merge write_data into the addressed word.
  - Set valid=1, dirty=1, tag=new tag.
- Writes do not change read_data.
- If read_enable and write_enable are both high, the write is performed, the read is ignored, and read_data holds its value.
- If neither enable is high, nothing changes.
- Repeating an enable across consecutive edges repeats the operation. After the first edge the access is a hit, so the repeats are idempotent.

## Timing
- Reset (rst_n low), applied immediately and regardless of clk:
  - read_data = 0.
  - All valid and dirty bits = 0.
  - Tags and data contents are don't-care.
  - Dirty data not yet written back is discarded.
- Reset mid-operation: the asynchronous clear wins, and no access is performed on any edge while rst_n is low.
- Latency is one edge for every case (hit, miss, write-back). read_data reflects the access on the rising edge where read_enable=1 and is stable until the next read edge or reset.
- Enables and addresses are sampled only at the rising edge. Values between edges have no effect.
- Write-back and fill happen on the same edge as the access. The write-back uses the old tag, and the fill reads memory after the write-back. This matters only when the old and new line addresses coincide, which is impossible on a miss.
- Index wrap: indices 0 and 1023 behave identically. Offsets 0 and 15 select the first and last word of a line, with no carry into the index.

## Test plan
- Reset, then read 0x1380B → read_data 0x0001380B after one edge. This is a miss; the line becomes valid and clean.
- Write 0x1380B with data 0x11111FFF (hit), then read 0x1380B → 0x11111FFF. Main memory word 0x1380B still holds 0x0001380B.
- Read 0x1F80B (same index, tag 7) → 0x0001F80B. The dirty line is evicted and memory word 0x1380B becomes 0x11111FFF.
- Read 0x1380B again → 0x11111FFF (miss, refilled from the written-back memory). Then write miss to 0x1780B with data 0xAAAA1111, read 0x1780B → 0xAAAA1111, and read 0x1780A → 0x0001780A (allocate filled the rest of the line).
- Simultaneous read_enable and write_enable, write 0x00005 with data 0xDEADBEEF → read_data unchanged. A following read of 0x00005 → 0xDEADBEEF.
- Drive rst_n low between clock edges after a dirty write → read_data 0 immediately. A following read of the same address → original memory contents (dirty data lost).
